// File: rtl/tluh_sram_adapter.sv
// TL-UH device endpoint: turns single-beat Get/Put/atomic/Intent requests on channel A into
// accesses on a req/gnt/rvalid SRAM port and returns the channel D response, one at a time.

package tluh_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AIW = 8;

    localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] ARITHMETIC_DATA  = 3'd2;
    localparam logic [2:0] LOGICAL_DATA     = 3'd3;
    localparam logic [2:0] GET              = 3'd4;
    localparam logic [2:0] INTENT           = 3'd5;

    localparam logic [2:0] ACCESS_ACK       = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tluh_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tluh_d2h_t;
endpackage

module tluh_sram_adapter
    import tluh_pkg::*;
#(
    parameter int SRAM_AW   = 10,
    parameter bit ERR_ON_SZ = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  tluh_h2d_t           tl_d_c_a,
    output tluh_d2h_t           tl_d_c_d,
    output logic                req_o,
    input  logic                gnt_i,
    output logic                we_o,
    output logic [SRAM_AW-1:0]  addr_o,
    output logic [TL_DW-1:0]    wdata_o,
    output logic [TL_DBW-1:0]   be_o,
    input  logic                rvalid_i,
    input  logic [TL_DW-1:0]    rdata_i,
    input  logic                err_i
);

    localparam int WORD_SIZE = $clog2(TL_DBW);
    localparam logic [TL_SZW-1:0] WORD_SZ = TL_SZW'(WORD_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT_R = 3'd2,
        ST_WB     = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    function automatic logic is_put(input logic [2:0] op);
        return (op == PUT_FULL_DATA) || (op == PUT_PARTIAL_DATA);
    endfunction

    function automatic logic is_atomic(input logic [2:0] op);
        return (op == ARITHMETIC_DATA) || (op == LOGICAL_DATA);
    endfunction

    function automatic logic bad_param(input logic [2:0] op, input logic [2:0] prm);
        logic bad;
        case (op)
            ARITHMETIC_DATA: bad = (prm > 3'd4);
            LOGICAL_DATA:    bad = (prm > 3'd3);
            default:         bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Compare and add see the whole word; byte masking is left to be_o on the write-back.
    function automatic logic [TL_DW-1:0] amo_result(input logic [2:0] op, input logic [2:0] prm,
                                                    input logic [TL_DW-1:0] old,
                                                    input logic [TL_DW-1:0] operand);
        logic [TL_DW-1:0] res;
        res = old;
        case (op)
            ARITHMETIC_DATA: begin
                case (prm)
                    3'd0:    res = ($signed(old) < $signed(operand)) ? old : operand;
                    3'd1:    res = ($signed(old) > $signed(operand)) ? old : operand;
                    3'd2:    res = (old < operand) ? old : operand;
                    3'd3:    res = (old > operand) ? old : operand;
                    3'd4:    res = old + operand;
                    default: res = old;
                endcase
            end
            LOGICAL_DATA: begin
                case (prm)
                    3'd0:    res = old ^ operand;
                    3'd1:    res = old | operand;
                    3'd2:    res = old & operand;
                    3'd3:    res = operand;
                    default: res = old;
                endcase
            end
            default: res = old;
        endcase
        return res;
    endfunction

    state_e              state_q, state_d;
    logic [2:0]          opcode_q, opcode_d;
    logic [2:0]          param_q, param_d;
    logic [TL_AIW-1:0]   source_q, source_d;
    logic [TL_SZW-1:0]   size_q, size_d;
    logic [TL_DBW-1:0]   mask_q, mask_d;
    logic [SRAM_AW-1:0]  waddr_q, waddr_d;
    logic [TL_DW-1:0]    data_q, data_d;
    logic [TL_DW-1:0]    old_q, old_d;
    logic [TL_DW-1:0]    new_q, new_d;
    logic                err_q, err_d;

    logic                a_ready_q, a_ready_d;
    logic                d_valid_q, d_valid_d;
    logic [2:0]          d_opcode_q, d_opcode_d;
    logic [TL_DW-1:0]    d_data_q, d_data_d;
    logic                d_error_q, d_error_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [TL_DBW-1:0]   be_q, be_d;
    logic [TL_DW-1:0]    wdata_q, wdata_d;

    logic                sz_err_s;
    logic                bad_op_s;
    logic                unused_addr_s;

    assign sz_err_s = ERR_ON_SZ &&
                      ((tl_d_c_a.a_size != WORD_SZ) ||
                       (tl_d_c_a.a_address[WORD_SIZE-1:0] != {WORD_SIZE{1'b0}}));
    assign bad_op_s = (tl_d_c_a.a_opcode > INTENT);
    assign unused_addr_s = ^tl_d_c_a.a_address[TL_AW-1:SRAM_AW+WORD_SIZE];

    // Next-state and transaction-context update.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        param_d  = param_q;
        source_d = source_q;
        size_d   = size_q;
        mask_d   = mask_q;
        waddr_d  = waddr_q;
        data_d   = data_q;
        old_d    = old_q;
        new_d    = new_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (tl_d_c_a.a_valid) begin
                    opcode_d = tl_d_c_a.a_opcode;
                    param_d  = tl_d_c_a.a_param;
                    source_d = tl_d_c_a.a_source;
                    size_d   = tl_d_c_a.a_size;
                    mask_d   = tl_d_c_a.a_mask;
                    waddr_d  = tl_d_c_a.a_address[SRAM_AW+WORD_SIZE-1:WORD_SIZE];
                    data_d   = tl_d_c_a.a_data;
                    old_d    = {TL_DW{1'b0}};
                    new_d    = {TL_DW{1'b0}};
                    if ((tl_d_c_a.a_opcode == INTENT) || sz_err_s || bad_op_s) begin
                        state_d = ST_RESP;
                        err_d   = sz_err_s | bad_op_s;
                    end else begin
                        state_d = ST_ISSUE;
                        err_d   = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (gnt_i) begin
                    if (is_put(opcode_q)) begin
                        state_d = ST_RESP;
                        err_d   = err_q | err_i;
                    end else begin
                        state_d = ST_WAIT_R;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_R: begin
                if (rvalid_i) begin
                    old_d = rdata_i;
                    if (is_atomic(opcode_q) && !err_i && !bad_param(opcode_q, param_q)) begin
                        state_d = ST_WB;
                        new_d   = amo_result(opcode_q, param_q, rdata_i, data_q);
                    end else begin
                        state_d = ST_RESP;
                        err_d   = err_q | err_i | bad_param(opcode_q, param_q);
                    end
                end else begin
                    state_d = ST_WAIT_R;
                end
            end
            ST_WB: begin
                if (gnt_i) begin
                    state_d = ST_RESP;
                    err_d   = err_q | err_i;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_RESP: begin
                if (tl_d_c_a.d_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so every port is a flop.
    always_comb begin
        a_ready_d  = (state_d == ST_IDLE);
        d_valid_d  = (state_d == ST_RESP);
        req_d      = (state_d == ST_ISSUE) || (state_d == ST_WB);
        we_d       = 1'b0;
        be_d       = {TL_DBW{1'b0}};
        wdata_d    = {TL_DW{1'b0}};
        d_opcode_d = ACCESS_ACK;
        d_data_d   = {TL_DW{1'b0}};
        d_error_d  = 1'b0;
        case (state_d)
            ST_ISSUE: begin
                if (is_put(opcode_d)) begin
                    we_d    = 1'b1;
                    be_d    = mask_d;
                    wdata_d = data_d;
                end else begin
                    we_d    = 1'b0;
                    be_d    = {TL_DBW{1'b1}};
                    wdata_d = {TL_DW{1'b0}};
                end
            end
            ST_WB: begin
                we_d    = 1'b1;
                be_d    = mask_d;
                wdata_d = new_d;
            end
            ST_RESP: begin
                d_error_d = err_d;
                if ((opcode_d == GET) || is_atomic(opcode_d)) begin
                    d_opcode_d = ACCESS_ACK_DATA;
                    d_data_d   = old_d;
                end else begin
                    d_opcode_d = ACCESS_ACK;
                    d_data_d   = {TL_DW{1'b0}};
                end
            end
            default: begin
                we_d    = 1'b0;
                be_d    = {TL_DBW{1'b0}};
                wdata_d = {TL_DW{1'b0}};
            end
        endcase
    end

    // State, context and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            opcode_q   <= 3'd0;
            param_q    <= 3'd0;
            source_q   <= {TL_AIW{1'b0}};
            size_q     <= {TL_SZW{1'b0}};
            mask_q     <= {TL_DBW{1'b0}};
            waddr_q    <= {SRAM_AW{1'b0}};
            data_q     <= {TL_DW{1'b0}};
            old_q      <= {TL_DW{1'b0}};
            new_q      <= {TL_DW{1'b0}};
            err_q      <= 1'b0;
            a_ready_q  <= 1'b1;
            d_valid_q  <= 1'b0;
            d_opcode_q <= ACCESS_ACK;
            d_data_q   <= {TL_DW{1'b0}};
            d_error_q  <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= {TL_DBW{1'b0}};
            wdata_q    <= {TL_DW{1'b0}};
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            param_q    <= param_d;
            source_q   <= source_d;
            size_q     <= size_d;
            mask_q     <= mask_d;
            waddr_q    <= waddr_d;
            data_q     <= data_d;
            old_q      <= old_d;
            new_q      <= new_d;
            err_q      <= err_d;
            a_ready_q  <= a_ready_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_data_q   <= d_data_d;
            d_error_q  <= d_error_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = waddr_q;
    assign wdata_o = wdata_q;
    assign be_o    = be_q;

    assign tl_d_c_d = '{
        d_valid:  d_valid_q,
        d_opcode: d_opcode_q,
        d_param:  3'd0,
        d_size:   size_q,
        d_source: source_q,
        d_sink:   1'b0,
        d_data:   d_data_q,
        d_error:  d_error_q,
        a_ready:  a_ready_q
    };

endmodule
